// File: rtl/phy_pkg.sv
// Shared PHY definitions: symbol values and receive-side state encodings.
package phy_pkg;

  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] COM_CHAR = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/phy_rx_deser_align_if.sv
// Serial-in / byte-out bundle between the line and the lane un-striping logic.
interface phy_rx_deser_align_if;

  logic                        data_in;
  logic [phy_pkg::DATA_W-1:0]  data_out;
  logic                        valid_out;
  logic                        active;

  modport master (output data_in, input data_out, input valid_out, input active);
  modport slave  (input data_in, output data_out, output valid_out, output active);

endinterface

// File: rtl/phy_rx_deser_align_shift8.sv
// 8-bit serial-in shift register; window is the byte that would be held after this edge.
module rx_shift8
  import phy_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              data_in,
  output logic [DATA_W-1:0] window
);

  logic [DATA_W-1:0] sr;

  // MSB arrives first, so new bits enter at the LSB end.
  assign window = {sr[DATA_W-2:0], data_in};

  always_ff @(posedge clk) begin
    if (reset) sr <= '0;
    else       sr <= window;
  end

endmodule

// File: rtl/phy_rx_deser_align.sv
// Byte-alignment FSM: hunts for COM, confirms COM_COUNT aligned COMs, then forwards payload.
module phy_rx_deser_align
  import phy_pkg::*;
#(
  parameter int COM_COUNT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  phy_rx_deser_align_if.slave  rx
);

  localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

  logic [DATA_W-1:0] window;
  rx_state_e         state;
  logic [2:0]        bit_cnt;
  logic [3:0]        com_cnt;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              active_q;
  logic              boundary;
  logic              is_com;

  rx_shift8 u_shift (
    .clk    (clk),
    .reset  (reset),
    .data_in(rx.data_in),
    .window (window)
  );

  assign boundary = (bit_cnt == 3'd7);
  assign is_com   = (window == COM_CHAR);

  // NOTE: all state here uses non-blocking assignments so every register sees
  // pre-edge values; a blocking write would leak into later reads this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SEARCH;
      bit_cnt  <= '0;
      com_cnt  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        SEARCH: begin
          if (is_com) begin
            bit_cnt <= '0;
            com_cnt <= 4'd1;
            if (COM_TARGET == 4'd1) begin
              state    <= ACTIVE;
              active_q <= 1'b1;
            end else begin
              state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (is_com) begin
              com_cnt <= com_cnt + 4'd1;
              if (com_cnt + 4'd1 == COM_TARGET) begin
                state    <= ACTIVE;
                active_q <= 1'b1;
              end
            end else begin
              // Broken run: resume hunting from the next bit, not this window.
              com_cnt <= '0;
              state   <= SEARCH;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary && !is_com) begin
            data_q  <= window;
            valid_q <= 1'b1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  assign rx.data_out  = data_q;
  assign rx.valid_out = valid_q;
  assign rx.active    = active_q;

endmodule

// File: tb/tb_phy_rx_deser_align.sv
// Bit-accurate bench for phy_rx_deser_align against a bit-history reference model.
module tb_phy_rx_deser_align;

  localparam int COM_COUNT = 4;

  logic clk = 1'b0;
  logic reset;

  phy_rx_deser_align_if bus ();

  phy_rx_deser_align #(.COM_COUNT(COM_COUNT)) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int strobe_cycles[$];

  // Reference model: mode 0 hunting, 1 counting COMs, 2 locked.
  int         m_win, m_mode, m_pos, m_run;
  logic [7:0] m_data;
  logic       m_valid, m_locked;

  function automatic void model_reset();
    m_win = 0; m_mode = 0; m_pos = 0; m_run = 0;
    m_data = 8'h00; m_valid = 1'b0; m_locked = 1'b0;
  endfunction

  function automatic void model_bit(bit b);
    m_win   = (m_win * 2 + int'(b)) % 256;
    m_valid = 1'b0;
    if (m_mode == 0) begin
      if (m_win == 188) begin
        m_pos  = 0;
        m_run  = 1;
        m_mode = (m_run >= COM_COUNT) ? 2 : 1;
      end
    end else begin
      m_pos = m_pos + 1;
      if (m_pos % 8 == 0) begin
        if (m_mode == 1) begin
          if (m_win == 188) begin
            m_run = m_run + 1;
            if (m_run == COM_COUNT) m_mode = 2;
          end else begin
            m_run  = 0;
            m_mode = 0;
          end
        end else if (m_win != 188) begin
          m_data  = 8'(m_win);
          m_valid = 1'b1;
        end
      end
    end
    m_locked = (m_mode == 2);
  endfunction

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive_bit(input bit b, input bit rst = 1'b0);
    @(negedge clk);
    bus.data_in = b;
    reset       = rst;
    if (rst) model_reset();
    else     model_bit(b);
    @(posedge clk);
    #1;
    cyc++;
    if (bus.valid_out === 1'b1) strobe_cycles.push_back(cyc);
    cmp("data_out",  bus.data_out,             m_data);
    cmp("valid_out", {7'b0, bus.valid_out},    {7'b0, m_valid});
    cmp("active",    {7'b0, bus.active},       {7'b0, m_locked});
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) drive_bit(v[i]);
  endtask

  task automatic send_rand_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(bit'($urandom_range(0, 1)));
  endtask

  initial begin
    reset       = 1'b1;
    bus.data_in = 1'b0;
    model_reset();

    // 1: reset held with toggling input
    for (int i = 0; i < 3; i++) drive_bit(bit'(i % 2), 1'b1);

    // 2: random lead-in, lock on 4 COMs, two payload bytes 8 clocks apart
    send_rand_bits(3);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    cmp("active_before_4th_com", {7'b0, bus.active}, 8'h00);
    send_byte(8'hBC);
    cmp("active_at_4th_com", {7'b0, bus.active}, 8'h01);
    strobe_cycles.delete();
    send_byte(8'h12);
    cmp("byte_12", bus.data_out, 8'h12);
    send_byte(8'h34);
    cmp("byte_34", bus.data_out, 8'h34);
    cmp("strobes_12_34", 8'(strobe_cycles.size()), 8'd2);
    if (strobe_cycles.size() == 2)
      cmp("spacing_8", 8'(strobe_cycles[1] - strobe_cycles[0]), 8'd8);

    // 3: idle COMs inside an active stream hold data_out and suppress strobes
    strobe_cycles.delete();
    send_byte(8'h56);
    send_byte(8'hBC);
    send_byte(8'hBC);
    cmp("hold_56", bus.data_out, 8'h56);
    send_byte(8'h78);
    cmp("byte_78", bus.data_out, 8'h78);
    cmp("strobes_56_78", 8'(strobe_cycles.size()), 8'd2);
    if (strobe_cycles.size() == 2)
      cmp("spacing_24", 8'(strobe_cycles[1] - strobe_cycles[0]), 8'd24);

    // 4: broken COM run must restart the count
    drive_bit(1'b0, 1'b1);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'hAA);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    cmp("no_lock_after_break", {7'b0, bus.active}, 8'h00);
    send_byte(8'hBC);
    cmp("lock_after_break", {7'b0, bus.active}, 8'h01);
    send_byte(8'h9F);
    cmp("byte_9f", bus.data_out, 8'h9F);

    // 5: reset mid-byte while locked, then a fresh lock
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    drive_bit(1'b1, 1'b1);
    cmp("reset_data", bus.data_out, 8'h00);
    cmp("reset_active", {7'b0, bus.active}, 8'h00);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    cmp("relock_pending", {7'b0, bus.active}, 8'h00);
    send_byte(8'hBC);
    cmp("relock_done", {7'b0, bus.active}, 8'h01);

    // 6: misaligned start, alignment follows the COM boundary
    drive_bit(1'b0, 1'b1);
    send_rand_bits(5);
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
    send_byte(8'hC3);
    cmp("byte_c3", bus.data_out, 8'hC3);

    // Random tail: random bytes and COMs after a random-offset lock
    drive_bit(1'b0, 1'b1);
    send_rand_bits(int'($urandom_range(0, 7)));
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) send_byte(8'hBC);
      else                           send_byte(8'($urandom));
    end
    send_rand_bits(64);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
